// File: rtl/ex_mem_pipe_if.sv
// EX/MEM stage bus: upstream handshake, downstream handshake, payload in/out and status.
// The slave side is the pipeline stage; the master side is its environment.
interface ex_mem_pipe_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
);
  logic              inp_valid;
  logic              out_ready;
  logic              out_valid;
  logic              inp_ready;
  logic              inp_hit;
  logic              inp_flush;

  logic              inp_zero;
  logic [DATA_W-1:0] inp_alu_result;
  logic [SEL_W-1:0]  inp_select_reg;
  logic [DATA_W-1:0] inp_data2;
  logic [DATA_W-1:0] inp_branch_address;
  logic              inp_mem_to_reg;
  logic              inp_reg_write;
  logic              inp_mem_read;
  logic              inp_mem_write;
  logic              inp_branch;

  logic              out_zero;
  logic [DATA_W-1:0] out_alu_result;
  logic [SEL_W-1:0]  out_select_reg;
  logic [DATA_W-1:0] out_data2;
  logic [DATA_W-1:0] out_branch_address;
  logic              out_mem_to_reg;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_branch;

  logic [1:0]        out_occupancy;
  logic [CNT_W-1:0]  out_stall_count;

  modport slave (
    input  inp_valid, inp_ready, inp_hit, inp_flush,
           inp_zero, inp_alu_result, inp_select_reg, inp_data2, inp_branch_address,
           inp_mem_to_reg, inp_reg_write, inp_mem_read, inp_mem_write, inp_branch,
    output out_ready, out_valid,
           out_zero, out_alu_result, out_select_reg, out_data2, out_branch_address,
           out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write, out_branch,
           out_occupancy, out_stall_count
  );

  modport master (
    output inp_valid, inp_ready, inp_hit, inp_flush,
           inp_zero, inp_alu_result, inp_select_reg, inp_data2, inp_branch_address,
           inp_mem_to_reg, inp_reg_write, inp_mem_read, inp_mem_write, inp_branch,
    input  out_ready, out_valid,
           out_zero, out_alu_result, out_select_reg, out_data2, out_branch_address,
           out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write, out_branch,
           out_occupancy, out_stall_count
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a 2-entry skid buffer, flush and cache-hit stall.
// State advances on the falling clock edge, like the other pipeline registers.
module ex_mem_pipe #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input logic          inp_clk,
  input logic          inp_rst_n,
  ex_mem_pipe_if.slave bus
);
  typedef struct packed {
    logic              zero;
    logic [DATA_W-1:0] alu_result;
    logic [SEL_W-1:0]  select_reg;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] branch_address;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
  } payload_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_d;
  payload_t         main_q, main_d;
  payload_t         skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  payload_t in_pl;
  logic     acc;
  logic     in_fire;

  assign in_pl.zero           = bus.inp_zero;
  assign in_pl.alu_result     = bus.inp_alu_result;
  assign in_pl.select_reg     = bus.inp_select_reg;
  assign in_pl.data2          = bus.inp_data2;
  assign in_pl.branch_address = bus.inp_branch_address;
  assign in_pl.mem_to_reg     = bus.inp_mem_to_reg;
  assign in_pl.reg_write      = bus.inp_reg_write;
  assign in_pl.mem_read       = bus.inp_mem_read;
  assign in_pl.mem_write      = bus.inp_mem_write;
  assign in_pl.branch         = bus.inp_branch;

  // A cache miss blocks downstream acceptance exactly like inp_ready=0.
  assign acc     = bus.inp_ready & bus.inp_hit;
  assign in_fire = bus.inp_valid & (state_q != FULL);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_pl;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && acc) begin
          main_d = in_pl;
        end else if (in_fire) begin
          skid_d  = in_pl;
          state_d = FULL;
        end else if (acc) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (acc) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over everything; stale data is harmless because controls are gated.
    if (bus.inp_flush) begin
      state_d = EMPTY;
    end

    if ((state_q != EMPTY) && !acc && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(negedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign bus.out_valid          = (state_q != EMPTY);
  assign bus.out_ready          = (state_q != FULL);
  assign bus.out_occupancy      = state_q;
  assign bus.out_stall_count    = stall_q;

  assign bus.out_zero           = main_q.zero;
  assign bus.out_alu_result     = main_q.alu_result;
  assign bus.out_select_reg     = main_q.select_reg;
  assign bus.out_data2          = main_q.data2;
  assign bus.out_branch_address = main_q.branch_address;

  // A bubble must never write memory or the register file.
  assign bus.out_mem_to_reg     = main_q.mem_to_reg & bus.out_valid;
  assign bus.out_reg_write      = main_q.reg_write  & bus.out_valid;
  assign bus.out_mem_read       = main_q.mem_read   & bus.out_valid;
  assign bus.out_mem_write      = main_q.mem_write  & bus.out_valid;
  assign bus.out_branch         = main_q.branch     & bus.out_valid;
endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX/MEM pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush and cache-hit stall. It sits between the ALU stage and the data-memory stage and carries the ALU result, zero flag, destination register select, store data, branch target and the five memory/writeback control bits. It replaces the fixed 16-bit, hit-gated EX/MEM latch. Upstream can keep issuing for one cycle after a downstream stall without a combinational ready path through the stage.

## Interface
- DATA_W, 16, width of alu_result, data2 and branch_address.
- SEL_W, 3, width of the destination register select.
- CNT_W, 16, width of the stall performance counter.
- inp_clk  in  1  stage clock. All state updates occur on the falling edge, matching the other pipeline registers.
- inp_rst_n  in  1  reset, asynchronous, active-low.
- inp_valid  in  1  upstream (EX) presents a valid payload.
- out_ready  out  1  stage can accept a payload this cycle.
- out_valid  out  1  output payload is valid.
- inp_ready  in  1  downstream (MEM) can accept.
- inp_hit  in  1  cache hit. 0 = memory stall, which blocks downstream acceptance.
- inp_flush  in  1  discard all held payloads (taken branch).
- inp_zero, inp_alu_result[DATA_W], inp_select_reg[SEL_W], inp_data2[DATA_W], inp_branch_address[DATA_W]  in  payload data.
- inp_mem_to_reg, inp_reg_write, inp_mem_read, inp_mem_write, inp_branch  in  1 each  payload control.
- out_zero, out_alu_result, out_select_reg, out_data2, out_branch_address  out  same widths  registered payload data.
- out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write, out_branch  out  1 each  payload control, AND-gated with out_valid.
- out_occupancy  out  2  entries held (0..2).
- out_stall_count  out  CNT_W  saturating count of stalled cycles.

## Operation
- Storage: main register (drives outputs) and skid register. States: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
- Derived signals:
  - in_fire = inp_valid & out_ready.
  - acc = inp_ready & inp_hit.
  - out_fire = out_valid & acc.
- out_ready = (state != FULL). It is a function of registered state only.
- out_valid = (state != EMPTY). out_occupancy = 0/1/2 for EMPTY/ONE/FULL.
- EMPTY: in_fire loads main and moves to ONE. Otherwise stay.
- ONE, depending on in_fire and acc:
  - in_fire & acc: main <= input, stay in ONE.
  - in_fire & !acc: skid <= input, move to FULL.
  - !in_fire & acc: move to EMPTY.
  - Neither: hold.
- FULL: in_fire is impossible. acc moves skid into main and goes to ONE. Otherwise hold both entries.
- Flush has the highest priority. inp_flush=1 on an edge forces EMPTY and discards both entries and any same-edge input. Data registers may keep stale values, but the gated control outputs read 0.
- Control outputs are 0 whenever out_valid=0, so a bubble never writes memory or the register file.
- Payload order is strictly FIFO. No payload is duplicated or dropped except by flush.
- out_stall_count increments on every edge where out_valid & !acc, including while flush is asserted. It saturates at 2^CNT_W-1 and is cleared only by reset.

## Timing
- Reset (asynchronous assert): state EMPTY, all payload registers 0, out_valid=0, out_ready=1, out_occupancy=0, out_stall_count=0, all control outputs 0.
- Reset deassertion takes effect at the next falling edge. Reset asserted mid-operation drops all entries immediately, with no edge required.
- Latency: an input accepted on a falling edge appears on the outputs after that same edge (1 edge), when the stage was EMPTY or ONE with acc=1.
- Throughput: 1 payload per cycle with acc held high.
- After a stall ends, the skid entry reaches the outputs one edge after acc returns to 1.
- out_ready falls on the edge entering FULL and rises on the edge leaving it. It has no combinational dependence on inp_ready, inp_hit or inp_flush.
- inp_hit=0 and inp_ready=0 are equivalent for flow control. Both must be stable before the falling edge.

## Test plan
- Reset: hold inp_rst_n=0, drive inp_valid=1 with data -> out_valid=0, out_ready=1, out_mem_write=0, out_stall_count=0. Release reset -> first payload alu_result=0x1234 appears after 1 falling edge.
- Streaming: send 0x0001..0x0008 back-to-back with acc=1 -> 8 consecutive outputs in order, out_occupancy never exceeds 1, out_stall_count=0.
- Skid: in ONE with payload A, drop inp_hit for 3 cycles while sending B -> FULL, out_ready=0, out_alu_result=A held, out_stall_count=3. Restore inp_hit -> A, then B, in the following cycles, with no loss.
- Flush while FULL with mem_write=1 entries -> next edge: out_valid=0, out_mem_write=0, out_occupancy=0. An input presented on the flush edge is discarded.
- Saturation with CNT_W=4: stall for 20 cycles -> out_stall_count stops at 15.
- Widths: DATA_W=32, SEL_W=5, payload 0xDEADBEEF and select 31 -> same values on the outputs, control bits gated correctly.
